block_dispatcher: RTL and testbench
===================================

// Module: block_dispatcher
// PURPOSE
//  Top-level job dispatcher for the block-matrix coprocessor. It walks every
//  C_ij output block of a mu x mu block grid in row-major order and hands each
//  (i,j) pair to a free control unit over the index handshake. It tracks each
//  CU's completion and raises o_Done once every block has been computed.
// PARAMETERS
//  NUM_CU      4  number of attached control units (>=1)
//  index_width 8  width of the row and column block indices
//  max_mu_log  8  width of i_mu; must satisfy max_mu_log <= index_width
// PORTS
//  i_Clock             in  1                    system clock, rising edge
//  i_Reset             in  1                    asynchronous, active-low reset
//  i_Start             in  1                    start a job; sampled in IDLE only
//  i_mu                in  max_mu_log           blocks per matrix dimension; latched at start
//  o_Busy              out 1                    high in every state except IDLE
//  o_Done              out 1                    1-cycle pulse when all mu*mu blocks are complete
//  o_Row_Index         out NUM_CU*index_width   per-CU i; slice n belongs to CU n
//  o_Column_Index      out NUM_CU*index_width   per-CU j; slice n belongs to CU n
//  o_Indexes_Ready     out NUM_CU               per-CU "indices valid" signal
//  i_Indexes_Received  in  NUM_CU               per-CU acknowledge
//  i_Result_Ready      in  NUM_CU               per-CU result-written level
// BEHAVIOUR
//  Reset (asynchronous, active-low): all outputs 0, all index slices 0,
//   state IDLE, all CUs marked free, result edge registers cleared.
//  States: IDLE -> DISPATCH -> WAIT_ACK -> (DISPATCH | DRAIN) -> DONE -> IDLE.
//  IDLE: when i_Start=1, latch mu, set i=0, j=0, issued=0.
//   If mu==0, go to DONE. Otherwise go to DISPATCH.
//  DISPATCH: if any CU is free, select the lowest-numbered free CU n.
//   Drive slice n with (i,j) and set o_Indexes_Ready[n]=1. Go to WAIT_ACK.
//   If no CU is free, stay in DISPATCH.
//  WAIT_ACK: hold slice n and Ready[n] stable until i_Indexes_Received[n]=1.
//   On that cycle: clear Ready[n], mark CU n busy, and advance the indices.
//   Advance rule: j+1; when j==mu-1, set j=0 and i+1. issued+1.
//   If issued reaches mu*mu, go to DRAIN. Otherwise go to DISPATCH.
//   Ready[n] is never high for more than one CU at a time.
//   Minimum cost per dispatch is 2 cycles.
//  Ack rule: Received[n] counts only while Ready[n]=1. CUs must hold
//   Received low whenever they are not accepting indices.
//  Completion: a 0->1 edge on i_Result_Ready[n] (registered prior sample)
//   while CU n is busy marks CU n free. Edges on free CUs are ignored.
//   Completion is monitored in every state.
//  Same-cycle free and dispatch: a CU freed this cycle can be selected in
//   DISPATCH on the next cycle, not this cycle.
//  DRAIN: wait until all CUs are free, then go to DONE.
//  DONE: o_Done=1 for exactly one cycle, then go to IDLE.
//  Start outside IDLE: i_Start is ignored. i_mu is used only as latched.
//  Width rules:
//   - issued counter is 2*max_mu_log bits wide; mu*mu is computed at the same width.
//   - i and j are zero-extended from the mu domain to index_width.
//  Reset mid-job: everything is abandoned immediately with no o_Done.
//   In-flight Ready lines drop asynchronously.
// TESTING
//  T1 reset: assert i_Reset=0 mid-DISPATCH -> Ready=0, Busy=0, Done=0
//     immediately; no Done after release.
//  T2 NUM_CU=4, mu=2, CUs ack 1 cycle after Ready -> (0,0)@CU0, (0,1)@CU1,
//     (1,0)@CU2, (1,1)@CU3; Done 1 cycle after last Result edge + DRAIN.
//  T3 NUM_CU=2, mu=3 -> 9 dispatches in row-major order; the 3rd (0,2) waits
//     until a Result edge frees a CU; Done pulses once.
//  T4 mu=0 start -> Busy high 1 cycle (DONE), Done pulse, no Ready asserted.
//  T5 CU1 Result edge in the same cycle CU0 acks -> CU1 is reused on the next
//     DISPATCH; indices never skip or repeat.
//  T6 i_Start toggled while Busy, i_mu changed mid-job -> ignored; the job
//     completes with the latched mu.

Source files
------------

// File: rtl/block_dispatcher_if.sv
// Index/result handshake bundle between the block dispatcher and its control units.
// Slice n of each index bus and bit n of each per-CU vector belong to CU n.
interface block_dispatcher_if #(
  parameter int NUM_CU      = 4,
  parameter int index_width = 8
);
  logic [NUM_CU*index_width-1:0] o_Row_Index;
  logic [NUM_CU*index_width-1:0] o_Column_Index;
  logic [NUM_CU-1:0]             o_Indexes_Ready;
  logic [NUM_CU-1:0]             i_Indexes_Received;
  logic [NUM_CU-1:0]             i_Result_Ready;

  modport master (
    output o_Row_Index, o_Column_Index, o_Indexes_Ready,
    input  i_Indexes_Received, i_Result_Ready
  );

  modport slave (
    input  o_Row_Index, o_Column_Index, o_Indexes_Ready,
    output i_Indexes_Received, i_Result_Ready
  );
endinterface

// File: rtl/block_dispatcher.sv
// Walks the mu x mu output-block grid in row-major order, handing each (i,j)
// to the lowest-numbered free control unit; pulses o_Done once all blocks finish.
module block_dispatcher #(
  parameter int NUM_CU      = 4,
  parameter int index_width = 8,
  parameter int max_mu_log  = 8
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Start,
  input  logic [max_mu_log-1:0] i_mu,
  output logic                  o_Busy,
  output logic                  o_Done,
  block_dispatcher_if.master    cu
);
  localparam int SEL_W = (NUM_CU > 1) ? $clog2(NUM_CU) : 1;
  localparam int CNT_W = 2 * max_mu_log;

  typedef enum logic [2:0] {IDLE, DISPATCH, WAIT_ACK, DRAIN, DONE} state_t;

  state_t                        r_state, w_stateNext;
  logic [max_mu_log-1:0]         r_mu, r_i, r_j;
  logic [CNT_W-1:0]              r_issued, w_total;
  logic [NUM_CU-1:0]             r_cuBusy, r_resultPrev, r_ready;
  logic [NUM_CU-1:0]             w_resultEdge, w_busyNext;
  logic [NUM_CU*index_width-1:0] r_row, r_col;
  logic [SEL_W-1:0]              r_sel, w_freeIdx;
  logic                          w_anyFree, w_start, w_dispatch, w_accept, w_lastCol;

  assign w_total      = CNT_W'(r_mu) * CNT_W'(r_mu);
  assign w_lastCol    = (r_j == r_mu - max_mu_log'(1));
  assign w_resultEdge = cu.i_Result_Ready & ~r_resultPrev;

  // Descending scan so the lowest-numbered free CU wins.
  always_comb begin
    w_anyFree = 1'b0;
    w_freeIdx = '0;
    for (int n = NUM_CU - 1; n >= 0; n--) begin
      if (!r_cuBusy[n]) begin
        w_anyFree = 1'b1;
        w_freeIdx = SEL_W'(n);
      end
    end
  end

  // A CU accepting indices this cycle is free, so a stray result edge on it cannot clear the new busy flag.
  always_comb begin
    w_busyNext = r_cuBusy & ~w_resultEdge;
    if (w_accept) w_busyNext[r_sel] = 1'b1;
  end

  always_comb begin
    w_stateNext = r_state;
    w_start     = 1'b0;
    w_dispatch  = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_Start) begin
          w_start     = 1'b1;
          w_stateNext = (i_mu == '0) ? DONE : DISPATCH;
        end
      end
      DISPATCH: begin
        if (w_anyFree) begin
          w_dispatch  = 1'b1;
          w_stateNext = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (cu.i_Indexes_Received[r_sel] && r_ready[r_sel]) begin
          w_accept    = 1'b1;
          w_stateNext = ((r_issued + CNT_W'(1)) == w_total) ? DRAIN : DISPATCH;
        end
      end
      DRAIN: begin
        if (r_cuBusy == '0) w_stateNext = DONE;
      end
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) r_state <= IDLE;
    else          r_state <= w_stateNext;
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_mu         <= '0;
      r_i          <= '0;
      r_j          <= '0;
      r_issued     <= '0;
      r_cuBusy     <= '0;
      r_resultPrev <= '0;
      r_ready      <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_sel        <= '0;
    end else begin
      r_resultPrev <= cu.i_Result_Ready;
      r_cuBusy     <= w_busyNext;
      if (w_start) begin
        r_mu     <= i_mu;
        r_i      <= '0;
        r_j      <= '0;
        r_issued <= '0;
      end
      if (w_dispatch) begin
        r_sel                                       <= w_freeIdx;
        r_ready[w_freeIdx]                          <= 1'b1;
        r_row[w_freeIdx*index_width +: index_width] <= index_width'(r_i);
        r_col[w_freeIdx*index_width +: index_width] <= index_width'(r_j);
      end
      if (w_accept) begin
        r_ready[r_sel] <= 1'b0;
        r_issued       <= r_issued + CNT_W'(1);
        if (w_lastCol) begin
          r_j <= '0;
          r_i <= r_i + max_mu_log'(1);
        end else begin
          r_j <= r_j + max_mu_log'(1);
        end
      end
    end
  end

  assign o_Busy             = (r_state != IDLE);
  assign o_Done             = (r_state == DONE);
  assign cu.o_Indexes_Ready = r_ready;
  assign cu.o_Row_Index     = r_row;
  assign cu.o_Column_Index  = r_col;
endmodule

// File: tb/tb_block_dispatcher.sv
// Directed bench for block_dispatcher: a 4-CU instance (A) and a 2-CU instance (B)
// whose CUs acknowledge indices one cycle after Ready; result edges are scripted.
module tb_block_dispatcher;
  logic       clock = 1'b0;
  logic       rstN;
  logic       startA, startB, busyA, busyB, doneA, doneB;
  logic [7:0] muA, muB;
  int         errors = 0;
  int         checks = 0;
  int         doneCntA = 0;
  int         doneCntB = 0;
  int         multiReady = 0;
  int         logA[$];
  int         logB[$];

  always #5 clock = ~clock;

  block_dispatcher_if #(.NUM_CU(4), .index_width(8)) ifA ();
  block_dispatcher_if #(.NUM_CU(2), .index_width(8)) ifB ();

  block_dispatcher #(.NUM_CU(4), .index_width(8), .max_mu_log(8)) dutA (
    .i_Clock(clock), .i_Reset(rstN), .i_Start(startA), .i_mu(muA),
    .o_Busy(busyA), .o_Done(doneA), .cu(ifA)
  );

  block_dispatcher #(.NUM_CU(2), .index_width(8), .max_mu_log(8)) dutB (
    .i_Clock(clock), .i_Reset(rstN), .i_Start(startB), .i_mu(muB),
    .o_Busy(busyB), .o_Done(doneB), .cu(ifB)
  );

  function automatic int key(input int cuN, input int row, input int col);
    return cuN * 65536 + row * 256 + col;
  endfunction

  function automatic int entryA(input int k);
    return (k < logA.size()) ? logA[k] : -1;
  endfunction

  function automatic int entryB(input int k);
    return (k < logB.size()) ? logB[k] : -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock: at the falling edge every CU with Ready high acknowledges and its indices are logged.
  task automatic step();
    @(negedge clock);
    ifA.i_Indexes_Received = '0;
    ifB.i_Indexes_Received = '0;
    for (int n = 0; n < 4; n++) begin
      if (ifA.o_Indexes_Ready[n]) begin
        ifA.i_Indexes_Received[n] = 1'b1;
        logA.push_back(key(n, int'(ifA.o_Row_Index[n*8 +: 8]), int'(ifA.o_Column_Index[n*8 +: 8])));
      end
    end
    for (int n = 0; n < 2; n++) begin
      if (ifB.o_Indexes_Ready[n]) begin
        ifB.i_Indexes_Received[n] = 1'b1;
        logB.push_back(key(n, int'(ifB.o_Row_Index[n*8 +: 8]), int'(ifB.o_Column_Index[n*8 +: 8])));
      end
    end
    if ($countones(ifA.o_Indexes_Ready) > 1 || $countones(ifB.o_Indexes_Ready) > 1) multiReady++;
    if (doneA) doneCntA++;
    if (doneB) doneCntB++;
  endtask

  task automatic applyStimulus(input bit onB, input logic [7:0] mu);
    if (onB) begin
      muB    = mu;
      startB = 1'b1;
    end else begin
      muA    = mu;
      startA = 1'b1;
    end
    step();
    startA = 1'b0;
    startB = 1'b0;
  endtask

  task automatic applyResult(input bit onB, input logic [3:0] mask);
    if (onB) ifB.i_Result_Ready = mask[1:0];
    else     ifA.i_Result_Ready = mask;
    step();
    ifA.i_Result_Ready = '0;
    ifB.i_Result_Ready = '0;
  endtask

  initial begin
    logic [3:0] maskB;
    int         expB[9];
    rstN = 1'b0;
    startA = 1'b0; startB = 1'b0;
    muA = '0; muB = '0;
    ifA.i_Indexes_Received = '0; ifA.i_Result_Ready = '0;
    ifB.i_Indexes_Received = '0; ifB.i_Result_Ready = '0;
    repeat (3) @(negedge clock);
    checkOutput("rst_busyA", busyA, 1'b0);
    checkOutput("rst_doneA", doneA, 1'b0);
    checkOutput("rst_readyA", ifA.o_Indexes_Ready, 4'b0000);
    checkOutput("rst_rowA", ifA.o_Row_Index, 32'h0);
    checkOutput("rst_busyB", busyB, 1'b0);
    rstN = 1'b1;
    repeat (2) step();

    $display("[TB] T1 reset mid-dispatch");
    logA.delete(); doneCntA = 0;
    applyStimulus(1'b0, 8'd2);
    step();
    checkOutput("t1_readyBefore", ifA.o_Indexes_Ready, 4'b0001);
    #2 rstN = 1'b0;
    #1;
    checkOutput("t1_readyAsync", ifA.o_Indexes_Ready, 4'b0000);
    checkOutput("t1_busyAsync", busyA, 1'b0);
    checkOutput("t1_doneAsync", doneA, 1'b0);
    ifA.i_Indexes_Received = '0;
    @(negedge clock);
    @(negedge clock);
    rstN = 1'b1;
    repeat (6) step();
    checkOutput("t1_noDone", doneCntA, 0);
    checkOutput("t1_busyAfter", busyA, 1'b0);
    checkOutput("t1_logCount", logA.size(), 1);

    $display("[TB] T2 mu=2 on four CUs");
    logA.delete(); doneCntA = 0;
    applyStimulus(1'b0, 8'd2);
    repeat (8) step();
    checkOutput("t2_logCount", logA.size(), 4);
    checkOutput("t2_disp0", entryA(0), key(0, 0, 0));
    checkOutput("t2_disp1", entryA(1), key(1, 0, 1));
    checkOutput("t2_disp2", entryA(2), key(2, 1, 0));
    checkOutput("t2_disp3", entryA(3), key(3, 1, 1));
    checkOutput("t2_busyDrain", busyA, 1'b1);
    applyResult(1'b0, 4'b0111);
    repeat (2) step();
    checkOutput("t2_noEarlyDone", doneCntA, 0);
    applyResult(1'b0, 4'b1000);
    checkOutput("t2_doneNotYet", doneA, 1'b0);
    step();
    checkOutput("t2_donePulse", doneA, 1'b1);
    step();
    checkOutput("t2_doneLow", doneA, 1'b0);
    checkOutput("t2_idle", busyA, 1'b0);
    checkOutput("t2_doneCount", doneCntA, 1);

    $display("[TB] T4 mu=0");
    logA.delete(); doneCntA = 0;
    applyStimulus(1'b0, 8'd0);
    checkOutput("t4_busyDone", busyA, 1'b1);
    checkOutput("t4_donePulse", doneA, 1'b1);
    step();
    checkOutput("t4_busyIdle", busyA, 1'b0);
    checkOutput("t4_doneCount", doneCntA, 1);
    checkOutput("t4_noReady", logA.size(), 0);

    $display("[TB] T5 same-cycle free and ack");
    logA.delete(); doneCntA = 0;
    applyStimulus(1'b0, 8'd3);
    repeat (9) step();
    checkOutput("t5_stalled", logA.size(), 4);
    applyResult(1'b0, 4'b0001);
    step();
    ifA.i_Result_Ready = 4'b0010;
    step();
    ifA.i_Result_Ready = '0;
    step();
    checkOutput("t5_disp4", entryA(4), key(0, 1, 1));
    checkOutput("t5_reuseCu1", entryA(5), key(1, 1, 2));
    step();
    applyResult(1'b0, 4'b1111);
    repeat (6) step();
    applyResult(1'b0, 4'b0111);
    repeat (2) step();
    checkOutput("t5_logCount", logA.size(), 9);
    checkOutput("t5_disp8", entryA(8), key(2, 2, 2));
    for (int k = 0; k < 9; k++) begin
      checkOutput($sformatf("t5_order%0d", k), entryA(k) & 32'hFFFF, key(0, k / 3, k % 3));
    end
    checkOutput("t5_doneCount", doneCntA, 1);
    checkOutput("t5_idle", busyA, 1'b0);

    $display("[TB] T3 mu=3 on two CUs");
    logB.delete(); doneCntB = 0;
    expB = '{key(0, 0, 0), key(1, 0, 1), key(1, 0, 2), key(0, 1, 0), key(1, 1, 1),
             key(0, 1, 2), key(1, 2, 0), key(0, 2, 1), key(1, 2, 2)};
    applyStimulus(1'b1, 8'd3);
    repeat (6) step();
    checkOutput("t3_thirdWaits", logB.size(), 2);
    checkOutput("t3_noReady", ifB.o_Indexes_Ready, 2'b00);
    maskB = 4'b0010;
    applyResult(1'b1, maskB);
    repeat (2) step();
    maskB = 4'b0011;
    repeat (4) begin
      applyResult(1'b1, maskB);
      repeat (4) step();
    end
    checkOutput("t3_logCount", logB.size(), 9);
    for (int k = 0; k < 9; k++) begin
      checkOutput($sformatf("t3_disp%0d", k), entryB(k), expB[k]);
    end
    checkOutput("t3_doneCount", doneCntB, 1);
    checkOutput("t3_idle", busyB, 1'b0);

    $display("[TB] T6 start and mu changes ignored while busy");
    logB.delete(); doneCntB = 0;
    applyStimulus(1'b1, 8'd2);
    muB = 8'd3;
    for (int k = 0; k < 6; k++) begin
      startB = k[0];
      step();
    end
    startB = 1'b0;
    checkOutput("t6_firstTwo", logB.size(), 2);
    applyResult(1'b1, 4'b0011);
    repeat (4) step();
    checkOutput("t6_logCount", logB.size(), 4);
    checkOutput("t6_disp2", entryB(2), key(0, 1, 0));
    checkOutput("t6_disp3", entryB(3), key(1, 1, 1));
    checkOutput("t6_busyDrain", busyB, 1'b1);
    applyResult(1'b1, 4'b0011);
    repeat (2) step();
    checkOutput("t6_doneCount", doneCntB, 1);
    checkOutput("t6_idle", busyB, 1'b0);

    checkOutput("oneHotReady", multiReady, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
